// File: rtl/apb_slave_ctrl_pkg.sv
// Shared APB definitions: FSM state encoding, default address map and
// the address range-check helpers used by the slave controller and decoder.
package apb_slave_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } apb_state_t;

    // Default address map: RW registers at 0..4, RO registers at 5..7.
    localparam int APB_AWIDTH           = 4;
    localparam int APB_REGWN            = 5;
    localparam int APB_REGRN            = 3;
    localparam int APB_REGR_ADDR_OFFSET = 5;
    localparam int APB_CNT_W            = 4;

    function automatic logic in_rw_range(input int addr, input int regwn);
        return addr < regwn;
    endfunction

    function automatic logic in_ro_range(input int addr, input int regrn, input int offset);
        return (addr >= offset) && (addr < offset + regrn);
    endfunction

    // Unmapped addresses and writes into the read-only window are errors.
    function automatic logic addr_error(input int addr, input logic write,
                                        input int regwn, input int regrn, input int offset);
        logic rw_hit;
        logic ro_hit;
        rw_hit = in_rw_range(addr, regwn);
        ro_hit = in_ro_range(addr, regrn, offset);
        return (!rw_hit && !ro_hit) || (write && ro_hit);
    endfunction

    // Position of a mapped address in the one-hot select vector.
    function automatic int sel_index(input int addr, input int regwn, input int offset);
        return in_rw_range(addr, regwn) ? addr : addr - offset + regwn;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/apb_slave_ctrl_if.sv
// APB request/response signals between a master and the slave controller.
interface apb_slave_ctrl_if #(
    parameter int AWIDTH = 4
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR,
        input  PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR,
        output PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_ctrl_wait_cnt.sv
// Loadable down-counter that times the access-phase wait states.
module apb_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Load takes priority; decrement stops at zero.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave controller: tracks the transfer phases, inserts wait states,
// flags address/protocol errors and drives a one-hot register select.
module apb_slave_ctrl
    import apb_slave_ctrl_pkg::*;
#(
    parameter int AWIDTH           = APB_AWIDTH,
    parameter int REGWN            = APB_REGWN,
    parameter int REGRN            = APB_REGRN,
    parameter int REGR_ADDR_OFFSET = APB_REGR_ADDR_OFFSET,
    parameter int WAIT_CYCLES      = 1
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    apb_slave_ctrl_if.slave        apb,
    output logic [REGWN+REGRN-1:0] dec_sel,
    output logic                   dec_write,
    output logic [AWIDTH-1:0]      dec_addr,
    output logic [7:0]             err_cnt
);
    localparam int NSEL = REGWN + REGRN;

    // Reject address maps that overlap or do not fit the address space.
    if ((REGR_ADDR_OFFSET < REGWN) || (REGR_ADDR_OFFSET + REGRN > 2**AWIDTH)) begin : g_bad_map
        $error("apb_slave_ctrl: RO window overlaps RW registers or exceeds address space");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES >= 2**APB_CNT_W)) begin : g_bad_wait
        $error("apb_slave_ctrl: WAIT_CYCLES out of range");
    end

    apb_state_t      state;
    logic            err;
    logic            cnt_zero;
    logic            cnt_load;
    logic            cnt_dec;
    logic            setup_req;
    logic            access_ok;
    logic            mismatch;
    logic            err_next;
    logic            new_err;
    int              sel_idx;
    logic [NSEL-1:0] sel_vec;

    assign setup_req = apb.PSEL && !apb.PENABLE;
    assign access_ok = apb.PSEL && apb.PENABLE;
    // The master must hold address and direction for the whole transfer.
    assign mismatch  = (apb.PADDR != dec_addr) || (apb.PWRITE != dec_write);
    assign err_next  = err || mismatch;
    assign new_err   = addr_error(32'(apb.PADDR), apb.PWRITE, REGWN, REGRN, REGR_ADDR_OFFSET);
    assign sel_idx   = sel_index(32'(dec_addr), REGWN, REGR_ADDR_OFFSET);

    assign cnt_load  = (state == IDLE) && setup_req;
    assign cnt_dec   = ((state == SETUP) || (state == WAIT)) && access_ok && !cnt_zero;

    // One-hot decode of the latched address.
    // NOTE: default first so no path through the block leaves sel_vec holding a value (no latch).
    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < NSEL; i++) begin
            sel_vec[i] = (i == sel_idx);
        end
    end

    apb_wait_cnt #(
        .W (APB_CNT_W)
    ) u_wait_cnt (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (cnt_load),
        .load_val (APB_CNT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Transfer FSM with registered PREADY/PSLVERR/dec_sel and error counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            err         <= 1'b0;
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            dec_sel     <= '0;
            dec_write   <= 1'b0;
            dec_addr    <= '0;
            err_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup_req) begin
                        dec_addr  <= apb.PADDR;
                        dec_write <= apb.PWRITE;
                        err       <= new_err;
                        state     <= SETUP;
                    end
                end
                SETUP, WAIT: begin
                    if (!access_ok) begin
                        // Aborted transfer: no response, but it counts as an error.
                        err     <= 1'b0;
                        err_cnt <= sat_inc8(err_cnt);
                        state   <= IDLE;
                    end else begin
                        err <= err_next;
                        if (cnt_zero) begin
                            apb.PREADY  <= 1'b1;
                            apb.PSLVERR <= err_next;
                            dec_sel     <= err_next ? '0 : sel_vec;
                            if (err_next) begin
                                err_cnt <= sat_inc8(err_cnt);
                            end
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                RESP: begin
                    apb.PREADY  <= 1'b0;
                    apb.PSLVERR <= 1'b0;
                    dec_sel     <= '0;
                    err         <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed testbench for apb_slave_ctrl with default parameters (WAIT_CYCLES=1).
module tb_apb_slave_ctrl;

    logic       PCLK;
    logic       PRESETn;
    logic [7:0] dec_sel;
    logic       dec_write;
    logic [3:0] dec_addr;
    logic [7:0] err_cnt;

    int         tests;
    int         fails;
    logic [7:0] exp_cnt;
    time        t0;
    time        t1;

    apb_slave_ctrl_if #(.AWIDTH(4)) apb ();

    apb_slave_ctrl dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .apb       (apb),
        .dec_sel   (dec_sel),
        .dec_write (dec_write),
        .dec_addr  (dec_addr),
        .err_cnt   (err_cnt)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic bus_idle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = 4'd0;
    endtask

    // One complete transfer; leaves the bus in access phase so a following
    // call presents its setup in the cycle right after the response.
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic exp_err,
                        input logic [7:0] exp_sel, output time t_ready);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        tick();
        chk("setup_pready", apb.PREADY, 1'b0);
        apb.PENABLE = 1'b1;
        tick();
        chk("wait_pready", apb.PREADY, 1'b0);
        chk("wait_pslverr", apb.PSLVERR, 1'b0);
        chk("wait_dec_sel", dec_sel, 8'h00);
        tick();
        t_ready = $time;
        if (exp_err) exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
        chk("resp_pready", apb.PREADY, 1'b1);
        chk("resp_pslverr", apb.PSLVERR, exp_err);
        chk("resp_dec_sel", dec_sel, exp_sel);
        chk("resp_dec_addr", dec_addr, addr);
        chk("resp_dec_write", dec_write, wr);
        chk("resp_err_cnt", err_cnt, exp_cnt);
        tick();
        chk("post_pready", apb.PREADY, 1'b0);
        chk("post_pslverr", apb.PSLVERR, 1'b0);
        chk("post_dec_sel", dec_sel, 8'h00);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        exp_cnt = 8'd0;
        bus_idle();

        // Asynchronous reset before any clock edge
        PRESETn = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_pready", apb.PREADY, 1'b0);
        chk("rst_pslverr", apb.PSLVERR, 1'b0);
        chk("rst_dec_sel", dec_sel, 8'h00);
        chk("rst_dec_write", dec_write, 1'b0);
        chk("rst_dec_addr", dec_addr, 4'd0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        tick();
        tick();
        #3 PRESETn = 1'b1;
        tick();
        chk("idle_pready", apb.PREADY, 1'b0);

        // Write RW register 2: PREADY in 4th cycle, select bit 2
        xfer(1'b1, 4'd2, 1'b0, 8'b0000_0100, t0);
        bus_idle();
        tick();

        // Read RO register at 6 -> bit 6; write to it -> error
        xfer(1'b0, 4'd6, 1'b0, 8'b0100_0000, t0);
        xfer(1'b1, 4'd6, 1'b1, 8'h00, t0);
        chk("ro_write_err_cnt", err_cnt, 8'd1);

        // Unmapped read
        xfer(1'b0, 4'd9, 1'b1, 8'h00, t0);

        // Address changes 2 -> 3 during WAIT
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 4'd2;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        apb.PADDR = 4'd3;
        tick();
        exp_cnt = 8'd3;
        chk("chg_pready", apb.PREADY, 1'b1);
        chk("chg_pslverr", apb.PSLVERR, 1'b1);
        chk("chg_dec_sel", dec_sel, 8'h00);
        chk("chg_err_cnt", err_cnt, exp_cnt);
        tick();
        chk("chg_post_pready", apb.PREADY, 1'b0);

        // PSEL dropped during WAIT: abort, then an immediate new transfer
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 4'd1;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        bus_idle();
        tick();
        exp_cnt = 8'd4;
        chk("abort_pready", apb.PREADY, 1'b0);
        chk("abort_dec_sel", dec_sel, 8'h00);
        chk("abort_err_cnt", err_cnt, exp_cnt);
        xfer(1'b0, 4'd7, 1'b0, 8'h80, t0);

        // Back-to-back reads of 0 and 1
        xfer(1'b0, 4'd0, 1'b0, 8'h01, t0);
        xfer(1'b0, 4'd1, 1'b0, 8'h02, t1);
        chk("b2b_gap_ns", 32'(t1 - t0), 32'd40);
        bus_idle();
        tick();

        // Reset asserted in the middle of WAIT
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 4'd3;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        #2 PRESETn = 1'b0;
        #1;
        exp_cnt = 8'd0;
        chk("midrst_pready", apb.PREADY, 1'b0);
        chk("midrst_pslverr", apb.PSLVERR, 1'b0);
        chk("midrst_dec_sel", dec_sel, 8'h00);
        chk("midrst_dec_write", dec_write, 1'b0);
        chk("midrst_dec_addr", dec_addr, 4'd0);
        chk("midrst_err_cnt", err_cnt, 8'd0);
        #2 PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_no_pready", apb.PREADY, 1'b0);
        end
        bus_idle();
        tick();
        xfer(1'b1, 4'd4, 1'b0, 8'h10, t0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            xfer(1'b0, 4'd9, 1'b1, 8'h00, t0);
        end
        chk("sat_err_cnt", err_cnt, 8'd255);
        bus_idle();
        tick();
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 4'd0;
        tick();
        bus_idle();
        tick();
        chk("sat_abort_err_cnt", err_cnt, 8'd255);
        chk("sat_abort_pready", apb.PREADY, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_slave_ctrl.md
APB_SLAVE_CTRL -- requirements
Module: apb_slave_ctrl

Interface
REQ-001 Parameters SHALL be: AWIDTH 4, APB address width; REGWN 5, number of RW registers; REGRN 3, number of RO registers; REGR_ADDR_OFFSET 5, first RO address; WAIT_CYCLES 1, extra access-phase wait states (0..15).
REQ-002 PCLK  in  1  APB clock; all state updates on its rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 PSEL  in  1  APB slave select.
REQ-005 PENABLE  in  1  APB access-phase strobe.
REQ-006 PWRITE  in  1  1 = write, 0 = read.
REQ-007 PADDR  in  AWIDTH  register address.
REQ-008 PREADY  out  1  transfer-complete, registered.
REQ-009 PSLVERR  out  1  transfer error, valid only while PREADY=1, also drives the address decoder error input.
REQ-010 dec_sel  out  REGWN+REGRN  one-hot register select to the address decoder; bit i = RW register i (i<REGWN), bit REGWN+j = RO register j.
REQ-011 dec_write  out  1  latched PWRITE.
REQ-012 dec_addr  out  AWIDTH  latched PADDR.
REQ-013 err_cnt  out  8  saturating count of errored or aborted transfers.

Function
REQ-014 States SHALL be IDLE, SETUP, WAIT, RESP.
REQ-015 IDLE: on PSEL=1, PENABLE=0 the block SHALL latch PADDR, PWRITE into dec_addr, dec_write, load wait counter with WAIT_CYCLES, compute err, and go to SETUP; otherwise stay in IDLE.
REQ-016 err SHALL be set when dec_addr is outside [0, REGWN-1] and outside [REGR_ADDR_OFFSET, REGR_ADDR_OFFSET+REGRN-1], or when it is a write into the RO range.
REQ-017 SETUP: PSEL=1, PENABLE=1 SHALL go to RESP if counter is 0, else to WAIT.
REQ-018 WAIT: counter SHALL decrement each cycle; at 0 the block SHALL go to RESP.
REQ-019 In SETUP or WAIT, PADDR or PWRITE differing from latched values SHALL set err (sticky to end of transfer).
REQ-020 In SETUP or WAIT, PSEL=0 or PENABLE=0 SHALL abort: return to IDLE, no PREADY, no dec_sel pulse, err_cnt incremented.
REQ-021 RESP: PREADY=1 and PSLVERR=err for exactly one cycle, then unconditional return to IDLE.
REQ-022 Transfer length SHALL be WAIT_CYCLES+3 cycles from setup cycle to PREADY cycle inclusive.
REQ-023 dec_sel SHALL be one-hot exactly during RESP when err=0, all-zero otherwise; RO bit index = dec_addr-REGR_ADDR_OFFSET+REGWN.
REQ-024 err_cnt SHALL increment once per RESP with err=1 and once per abort, saturating at 255.
REQ-025 A setup phase presented in the cycle after RESP SHALL be accepted from IDLE without loss (back-to-back transfers).
REQ-026 PSLVERR SHALL be 0 whenever PREADY=0.

Reset
REQ-027 PRESETn=0 SHALL immediately force state IDLE, PREADY 0, PSLVERR 0, dec_sel 0, dec_write 0, dec_addr 0, err_cnt 0, counter 0, err 0.
REQ-028 Reset during SETUP, WAIT or RESP SHALL discard the transfer with no PREADY after release.

Structure
REQ-029 State encoding, address-map constants (REGWN, REGRN, REGR_ADDR_OFFSET defaults) and range-check function SHALL live in a shared APB package used also by the decoder.
REQ-030 Wait counter SHALL be a sub-module apb_wait_cnt (load, decrement, zero flag); all else in one module.
REQ-031 Elaboration SHALL fail if REGR_ADDR_OFFSET < REGWN or REGR_ADDR_OFFSET+REGRN > 2**AWIDTH.

Verification
REQ-032 Write PADDR=2, WAIT_CYCLES=1 -> PREADY high 4th cycle, PSLVERR=0, dec_sel=8'b0000_0100 that cycle only.
REQ-033 Read PADDR=6 -> PREADY, PSLVERR=0, dec_sel=8'b0100_0000; write PADDR=6 -> PSLVERR=1, dec_sel=0, err_cnt=1.
REQ-034 Read PADDR=9 (unmapped) -> PSLVERR=1 with PREADY; PADDR changed 2->3 in WAIT -> PSLVERR=1.
REQ-035 PSEL dropped in WAIT -> no PREADY, state IDLE next cycle, err_cnt+1; 260 error transfers -> err_cnt=255.
REQ-036 Two back-to-back reads PADDR=0 then 1 -> two PREADY pulses 4 cycles apart, dec_sel 8'h01 then 8'h02.
REQ-037 PRESETn asserted mid-WAIT -> all outputs 0 same cycle, no PREADY after release until new setup.
